debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer that replaces the single-input reset debouncer.
- Conditions N asynchronous board inputs (buttons, switches, reset request) into clean levels, plus one-cycle rise and fall event pulses.
- Sits between the board pins and the CPU, arbiter and interrupt logic.
- Adds a shared sample prescaler, per-channel reset levels and edge events, none of which the old block had.

Parameters:
- N, 8, number of channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- PRESCALE, 1000, clk cycles per sample tick (>=1; 1 = tick every cycle).
- STABLE, 50, consecutive differing ticks required to accept a new level (>=1).
- RESET_LEVEL, {N{1'b0}}, value of o_level during and after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion is immediate; release is synchronous to clk.
- i_raw  in  N  raw asynchronous inputs.
- o_level  out  N  debounced level per channel.
- o_rise  out  N  one-cycle pulse when o_level goes 0->1.
- o_fall  out  N  one-cycle pulse when o_level goes 1->0.
- o_any  out  1  OR of o_rise|o_fall, same cycle.
- o_tick  out  1  prescaler tick, for observation.

Behaviour:
- Reset values (rst=0): o_level=RESET_LEVEL; o_rise, o_fall, o_any, o_tick = 0; prescaler=0; all counters=0; synchroniser flops = RESET_LEVEL bits.
- Synchroniser: i_raw[k] passes through SYNC_STAGES flops to give s[k]. No other logic reads i_raw.
- Prescaler: width $clog2(PRESCALE+1). Free-running from reset release.
  - o_tick=1 in the cycle where pre==PRESCALE-1; pre then wraps to 0.
  - PRESCALE=1 gives o_tick=1 every cycle.
- Per-channel counter: width $clog2(STABLE+1).
  - s==o_level in any cycle: cnt<=0, tick or not. A glitch shorter than one tick therefore restarts the count.
  - s!=o_level and tick and cnt<STABLE-1: cnt<=cnt+1.
  - s!=o_level and tick and cnt==STABLE-1: o_level<=s, cnt<=0, and o_rise or o_fall asserted for exactly the next cycle (registered alongside o_level).
  - s!=o_level and no tick: cnt holds.
- Edge pulses: o_rise/o_fall are registered and high for one cycle only. Independent channels may pulse in the same cycle. Rise and fall never occur together on one channel.
- Latency, minimum to accept a change: SYNC_STAGES cycles plus STABLE ticks, i.e. up to SYNC_STAGES + STABLE*PRESCALE cycles, plus 1 cycle to the pulse output.
- Counter saturation: impossible by construction; cnt never exceeds STABLE-1.
- Reset mid-operation: rst=0 aborts all counts immediately, forces RESET_LEVEL and kills any pending pulse. After release, inputs that differ from RESET_LEVEL must qualify afresh.
- Input held at RESET_LEVEL through reset: no pulse after release.

Decomposition:
- Shared package (plp_pkg): clog2 helper function and the default constants DEB_PRESCALE and DEB_STABLE.
- Sub-module debounce_channel, one per channel via generate.
  - Contains: synchroniser, counter, level register, edge registers.
  - Inputs: clk, rst, tick, raw, reset level bit.
- Top of debounce_bank holds the prescaler and the o_any reduction.

Test Plan (N=4, SYNC_STAGES=2, PRESCALE=4, STABLE=3, RESET_LEVEL=4'b0001 unless noted):
- Reset check: hold rst=0 with i_raw=4'b1010.
  - Required: o_level=4'b0001, no pulses, o_tick=0.
  - Release and hold i_raw=4'b0001 for 100 cycles: no pulse ever.
- Clean press: i_raw[1] 0->1 and held.
  - Required: o_level[1]=1 after exactly 3 ticks of s[1]=1 (at most 2+12 cycles).
  - o_rise=4'b0010 for one cycle, o_any=1 in that cycle.
- Glitch rejection: i_raw[2] high for 6 cycles (spans 1 tick), then low.
  - Required: o_level[2] stays 0, no pulse, counter returns to 0.
- Release: channel 0 driven 1->0 and held.
  - Required: o_fall=4'b0001 once, o_level[0]=0.
- Simultaneous edges: channel 1 rises and channel 3 rises, driven in the same cycle.
  - Required: o_rise=4'b1010 in a single cycle.
- Reset mid-count: i_raw[3]=1 held, rst=0 asserted after 2 ticks.
  - Required: o_level[3]=0 at once.
  - After release, the rise occurs only after 3 full ticks; the pulse fires exactly once.
- PRESCALE=1 variant: o_tick constantly 1; a change is accepted 2+3 cycles after the input edge.

Source files
------------

// File: rtl/plp_pkg.sv
// -----------------------------------------------------------------------------
// plp_pkg
// Shared constants and helpers for the board-input conditioning blocks.
//
// Contents:
//   DEB_PRESCALE  default clk cycles per debounce sample tick
//   DEB_STABLE    default number of consecutive differing ticks to accept a level
//   clog2()       ceiling log2, clamped to at least 1 so it can size a vector
// -----------------------------------------------------------------------------
package plp_pkg;

   localparam int DEB_PRESCALE = 1000;
   localparam int DEB_STABLE   = 50;

   // Ceiling log2; a result of 0 would give a zero-width vector, so clamp to 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: synchroniser, stability counter, level register and
// registered rise/fall event pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   tick         shared sample tick from the prescaler
//   raw          raw asynchronous input
//   reset_level  level loaded into the synchroniser and level register in reset
//   level        debounced level
//   rise         one-cycle pulse when level goes 0->1
//   fall         one-cycle pulse when level goes 1->0
// -----------------------------------------------------------------------------
module debounce_channel
   import plp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE      = DEB_STABLE
)(
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   input  logic reset_level,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int               CW       = clog2(STABLE + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;

   // Synchroniser chain; it powers up at the reset level so an input already
   // sitting at that level produces no event after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= {SYNC_STAGES{reset_level}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
      end
   end

   assign s = sync[SYNC_STAGES-1];

   // Any cycle where the synchronised input agrees with the accepted level
   // clears the count, so a glitch shorter than one tick restarts qualification.
   // The count only advances on ticks and the level flips on the STABLE-th one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         level <= reset_level;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == level) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CNT_LAST) begin
               cnt   <= '0;
               level <= s;
               rise  <= s;
               fall  <= ~s;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Multi-channel debouncer: a shared sample prescaler feeding N independent
// debounce channels, plus an OR of all edge events.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   i_raw    [N] raw asynchronous inputs
//   o_level  [N] debounced levels
//   o_rise   [N] one-cycle pulse per channel on a 0->1 level change
//   o_fall   [N] one-cycle pulse per channel on a 1->0 level change
//   o_any    OR of all rise and fall pulses, same cycle
//   o_tick   prescaler sample tick, for observation
// -----------------------------------------------------------------------------
module debounce_bank
   import plp_pkg::*;
#(
   parameter int             N           = 8,
   parameter int             SYNC_STAGES = 2,
   parameter int             PRESCALE    = DEB_PRESCALE,
   parameter int             STABLE      = DEB_STABLE,
   parameter logic [N-1:0]   RESET_LEVEL = '0
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_raw,
   output logic [N-1:0] o_level,
   output logic [N-1:0] o_rise,
   output logic [N-1:0] o_fall,
   output logic         o_any,
   output logic         o_tick
);

   localparam int            PW       = clog2(PRESCALE + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;
   logic          tick;

   // Qualified by rst so that with PRESCALE=1 the tick stays low in reset.
   assign tick = rst & (pre == PRE_LAST);

   // Free-running prescaler; wraps to 0 in the cycle that raises the tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .STABLE      (STABLE)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .raw         (i_raw[k]),
         .reset_level (RESET_LEVEL[k]),
         .level       (o_level[k]),
         .rise        (o_rise[k]),
         .fall        (o_fall[k])
      );
   end

   assign o_any  = |(o_rise | o_fall);
   assign o_tick = tick;

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
// Self-checking bench for debounce_bank. Two instances share clk, rst and
// inputs: dut_a with PRESCALE=4 and dut_b with PRESCALE=1. A behavioural model
// predicts every output of both each cycle; directed scenarios add targeted
// checks, then a randomized phase runs with occasional resets.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

   localparam int           NCH  = 4;
   localparam int           SYNC = 2;
   localparam int           STAB = 3;
   localparam logic [3:0]   RLEV = 4'b0001;

   logic       clk;
   logic       rst_n;
   logic [3:0] i_raw;

   logic [3:0] o_level_a, o_rise_a, o_fall_a;
   logic       o_any_a, o_tick_a;
   logic [3:0] o_level_b, o_rise_b, o_fall_b;
   logic       o_any_b, o_tick_b;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   debounce_bank #(
      .N(NCH), .SYNC_STAGES(SYNC), .PRESCALE(4), .STABLE(STAB), .RESET_LEVEL(RLEV)
   ) dut_a (
      .clk(clk), .rst(rst_n), .i_raw(i_raw),
      .o_level(o_level_a), .o_rise(o_rise_a), .o_fall(o_fall_a),
      .o_any(o_any_a), .o_tick(o_tick_a)
   );

   debounce_bank #(
      .N(NCH), .SYNC_STAGES(SYNC), .PRESCALE(1), .STABLE(STAB), .RESET_LEVEL(RLEV)
   ) dut_b (
      .clk(clk), .rst(rst_n), .i_raw(i_raw),
      .o_level(o_level_b), .o_rise(o_rise_b), .o_fall(o_fall_b),
      .o_any(o_any_b), .o_tick(o_tick_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (observed !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Reference model: input delayed by the synchroniser depth, a sample tick
   // every P cycles after release, and per channel a run of consecutive ticks
   // that disagreed with the accepted level; STAB such ticks flip the level.
   logic [3:0] hist [SYNC];
   logic [3:0] m_level [2];
   logic [3:0] m_rise  [2];
   logic [3:0] m_fall  [2];
   int         m_run   [2][NCH];
   int         m_cyc   [2];

   function automatic int presc(input int m);
      return (m == 0) ? 4 : 1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < SYNC; i++) hist[i] = RLEV;
      for (int m = 0; m < 2; m++) begin
         m_level[m] = RLEV;
         m_rise[m]  = '0;
         m_fall[m]  = '0;
         m_cyc[m]   = 0;
         for (int k = 0; k < NCH; k++) m_run[m][k] = 0;
      end
   endtask

   task automatic modelStep();
      logic [3:0] s;
      bit         tk;
      s = hist[SYNC-1];
      for (int m = 0; m < 2; m++) begin
         tk = (m_cyc[m] == presc(m) - 1);
         m_rise[m] = '0;
         m_fall[m] = '0;
         for (int k = 0; k < NCH; k++) begin
            if (s[k] == m_level[m][k]) begin
               m_run[m][k] = 0;
            end else if (tk) begin
               m_run[m][k] = m_run[m][k] + 1;
               if (m_run[m][k] == STAB) begin
                  m_level[m][k] = s[k];
                  if (s[k]) m_rise[m][k] = 1'b1;
                  else      m_fall[m][k] = 1'b1;
                  m_run[m][k] = 0;
               end
            end
         end
         m_cyc[m] = (m_cyc[m] + 1) % presc(m);
      end
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = i_raw;
   endtask

   always @(posedge clk) begin
      if (!rst_n) modelReset();
      else        modelStep();
   end

   // Per-cycle comparison of every output of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("a_level", o_level_a, m_level[0]);
         checkOutput("a_rise",  o_rise_a,  m_rise[0]);
         checkOutput("a_fall",  o_fall_a,  m_fall[0]);
         checkOutput("a_any",   o_any_a,   |(m_rise[0] | m_fall[0]));
         checkOutput("a_tick",  o_tick_a,  rst_n && (m_cyc[0] == 3));
         checkOutput("b_level", o_level_b, m_level[1]);
         checkOutput("b_rise",  o_rise_b,  m_rise[1]);
         checkOutput("b_fall",  o_fall_b,  m_fall[1]);
         checkOutput("b_any",   o_any_b,   |(m_rise[1] | m_fall[1]));
         checkOutput("b_tick",  o_tick_b,  rst_n);
      end
   end

   // Pulse counters for dut_a, read by the directed scenarios.
   int rise_cnt [NCH];
   int fall_cnt [NCH];
   bit pair_seen;

   initial begin
      for (int k = 0; k < NCH; k++) begin
         rise_cnt[k] = 0;
         fall_cnt[k] = 0;
      end
      pair_seen = 1'b0;
   end

   always @(negedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (o_rise_a[k]) rise_cnt[k] = rise_cnt[k] + 1;
         if (o_fall_a[k]) fall_cnt[k] = fall_cnt[k] + 1;
      end
      if (o_rise_a == 4'b1010) pair_seen = 1'b1;
   end

   function automatic int totalPulses();
      int t;
      t = 0;
      for (int k = 0; k < NCH; k++) t = t + rise_cnt[k] + fall_cnt[k];
      return t;
   endfunction

   // Drives a value and holds it; activity sits 1 time unit after negedge.
   task automatic applyStimulus(input logic [3:0] v, input int cycles);
      i_raw = v;
      repeat (cycles) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int base;
      int lat;
      logic [3:0] v;

      rst_n = 1'b0;
      i_raw = 4'b1010;
      modelReset();
      chk_en = 1'b1;

      // Reset held with inputs away from the reset level.
      applyStimulus(4'b1010, 5);
      checkOutput("rst_level_a", o_level_a, 4'b0001);
      checkOutput("rst_level_b", o_level_b, 4'b0001);
      checkOutput("rst_pulse_a", o_rise_a | o_fall_a, 4'b0000);
      checkOutput("rst_tick_a",  o_tick_a, 1'b0);
      checkOutput("rst_tick_b",  o_tick_b, 1'b0);

      // Release with inputs at the reset level: nothing may ever fire.
      i_raw = 4'b0001;
      rst_n = 1'b1;
      base  = totalPulses();
      applyStimulus(4'b0001, 100);
      checkOutput("quiet_pulses", totalPulses() - base, 0);
      checkOutput("quiet_level", o_level_a, 4'b0001);

      // Clean press on channel 1.
      base = rise_cnt[1];
      lat  = -1;
      i_raw = 4'b0011;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         #1;
         if (o_rise_a[1] && lat < 0) lat = c;
      end
      checkOutput("press_rise_count", rise_cnt[1] - base, 1);
      checkOutput("press_level", o_level_a[1], 1'b1);
      checkOutput("press_latency_ok", (lat >= 1) && (lat <= 15), 1'b1);

      // Glitch on channel 2 spanning about one tick.
      base = rise_cnt[2] + fall_cnt[2];
      applyStimulus(4'b0111, 6);
      applyStimulus(4'b0011, 20);
      checkOutput("glitch_level", o_level_a[2], 1'b0);
      checkOutput("glitch_pulses", rise_cnt[2] + fall_cnt[2] - base, 0);

      // Channel 0 released from 1 to 0.
      base = fall_cnt[0];
      applyStimulus(4'b0010, 20);
      checkOutput("release_fall_count", fall_cnt[0] - base, 1);
      checkOutput("release_level", o_level_a[0], 1'b0);

      // Channels 1 and 3 rising from the same input edge.
      applyStimulus(4'b0000, 20);
      pair_seen = 1'b0;
      applyStimulus(4'b1010, 20);
      checkOutput("simul_rise_pair", pair_seen, 1'b1);
      checkOutput("simul_level", o_level_a, 4'b1010);

      // Reset in the middle of channel 3 qualifying.
      applyStimulus(4'b0000, 20);
      i_raw = 4'b1000;
      for (int c = 0; c < 20 && m_run[0][3] != 2; c++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("midreset_run_reached", m_run[0][3], 2);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("midreset_async_level", o_level_a, 4'b0001);
      checkOutput("midreset_async_pulse", o_rise_a | o_fall_a, 4'b0000);
      applyStimulus(4'b1000, 3);
      rst_n = 1'b1;
      base = rise_cnt[3];
      lat  = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         #1;
         if (o_rise_a[3] && lat < 0) lat = c;
      end
      checkOutput("midreset_rise_count", rise_cnt[3] - base, 1);
      checkOutput("midreset_rise_latency", lat, 12);

      // Randomized phase with occasional mid-cycle resets.
      for (int it = 0; it < 300; it++) begin
         v = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) begin
            rst_n = 1'b0;
            modelReset();
            applyStimulus(v, $urandom_range(1, 3));
            rst_n = 1'b1;
         end
         applyStimulus(v, $urandom_range(1, 16));
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
